// File: rtl/mem_port_arbiter.sv
// Multi-port arbiter in front of a single-port memory with fixed MEM_LATENCY.
// One transaction in flight: IDLE accepts, ISSUE drives memory, WAIT counts, RESP answers.
module mem_port_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 1,
  parameter int RR_MODE     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      req_valid,
  output logic [NUM_PORTS-1:0]      req_ready,
  input  logic [NUM_PORTS*XLEN-1:0] req_addr,
  input  logic [NUM_PORTS*XLEN-1:0] req_wdata,
  input  logic [NUM_PORTS*4-1:0]    req_byte_en,
  input  logic [NUM_PORTS-1:0]      req_we,
  input  logic [NUM_PORTS-1:0]      flush,
  output logic [NUM_PORTS-1:0]      resp_valid,
  output logic [XLEN-1:0]           resp_rdata,
  output logic                      busy,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [XLEN-1:0]           mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  output logic [3:0]                mem_byte_en,
  input  logic [XLEN-1:0]           mem_rdata
);
  localparam int IW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            we;
  } req_t;

  logic [NUM_PORTS-1:0][XLEN-1:0] addr_v, wdata_v;
  logic [NUM_PORTS-1:0][3:0]      be_v;
  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign be_v    = req_byte_en;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            cancel_q, cancel_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  req_t            lat_q, lat_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  // Winner search: RR rotates the start one past the last accepted port.
  logic          found;
  logic [IW-1:0] win;
  logic [IW:0]   j;
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (RR_MODE != 0) j = (IW+1)'(last_q) + (IW+1)'(i) + (IW+1)'(1);
      else              j = (IW+1)'(i);
      if (j >= (IW+1)'(NUM_PORTS)) j = j - (IW+1)'(NUM_PORTS);
      if (!found && req_valid[j[IW-1:0]]) begin
        found = 1'b1;
        win   = j[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cancel_d    = cancel_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    req_ready   = '0;
    resp_valid  = '0;
    resp_rdata  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = '0;
    unique case (state_q)
      IDLE: begin
        // reset gate keeps req_ready low while reset is held
        if (found && reset) begin
          req_ready[win] = 1'b1;
          gnt_d          = win;
          last_d         = win;
          lat_d          = '{addr: addr_v[win], wdata: wdata_v[win], be: be_v[win], we: req_we[win]};
          cancel_d       = 1'b0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        mem_req     = 1'b1;
        mem_we      = lat_q.we;
        mem_addr    = lat_q.addr;
        mem_wdata   = lat_q.wdata;
        mem_byte_en = lat_q.be;
        cnt_d       = 4'd1;
        if (flush[gnt_q]) cancel_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (flush[gnt_q]) cancel_d = 1'b1;
        if (cnt_q == 4'(MEM_LATENCY)) begin
          rdata_d = lat_q.we ? '0 : mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (!cancel_q && !flush[gnt_q]) begin
          resp_valid[gnt_q] = 1'b1;
          resp_rdata        = rdata_q;
        end
        cnt_d    = '0;
        cancel_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
      last_q   <= IW'(NUM_PORTS-1);
      gnt_q    <= '0;
      lat_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cancel_q <= cancel_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      lat_q    <= lat_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule
